// File: rtl/game_pkg.sv
// Shared types and constants for the 8x8 red/green playfield game controller.
package game_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} game_state_t;

  localparam int BIRD_COL = 6;
  localparam int ROWS     = 8;
  localparam int ROW_W    = $clog2(ROWS);
  localparam int SCORE_W  = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Step period shrinks by TICK_DIV/8 for every 8 points, never below TICK_DIV/4.
  function automatic int step_period(input int tick_div, input int score_v);
    int sub;
    int floor_p;
    sub     = (score_v / 8) * (tick_div / 8);
    floor_p = tick_div / 4;
    if (tick_div - sub < floor_p) return floor_p;
    return tick_div - sub;
  endfunction

endpackage

// File: rtl/game_sequencer_step_timer.sv
// Game-step divider: free-running tick counter that wraps after `period` cycles while run is high.
module step_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
  input  logic [TW-1:0] period,
  output logic          wrap
);

  logic [TW-1:0] tick;

  // >= keeps the wrap safe if the period shrinks below the current count
  assign wrap = run && (tick >= period - TW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          tick <= '0;
    else if (!run || wrap) tick <= '0;
    else                   tick <= tick + TW'(1);
  end

endmodule

// File: rtl/game_sequencer.sv
// Top-level game controller: step timing, bird motion, collision check and scoring.
// Optional macro SEQ_SPEEDUP_EN shortens the step period as the score grows.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 25000000,
  parameter int FLAP_ROWS   = 2,
  parameter int PIPE_PERIOD = 4,
  parameter int START_ROW   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               flap,
  input  logic               dead,
  output logic               scroll_en,
  output logic               clear_field,
  output logic [ROW_W-1:0]   bird_row,
  output logic [SCORE_W-1:0] score,
  output logic               playing,
  output logic               game_over
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(PIPE_PERIOD + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  game_state_t   state, state_nxt;
  logic [TW-1:0] period;
  logic [SW-1:0] step_cnt;
  logic          flap_pending, floor_hit, wrap, run, crash;

  assign run   = (state == PLAY) || (state == CHECK);
  assign crash = dead || floor_hit;

`ifdef SEQ_SPEEDUP_EN
  // Score settles at CHECK; the new period is adopted at the following wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           period <= TW'(TICK_DIV);
    else if (state == IDLE) period <= TW'(TICK_DIV);
    else if (wrap)          period <= TW'(step_period(TICK_DIV, int'(score)));
  end
`else
  assign period = TW'(TICK_DIV);
`endif

  step_timer #(.TW(TW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .period  (period),
    .wrap    (wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PLAY;
      PLAY:    if (wrap)  state_nxt = CHECK;
      CHECK:   state_nxt = crash ? OVER : PLAY;
      OVER:    if (start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clear_field = (state == IDLE) && start;
    scroll_en   = (state == PLAY) && wrap;
    playing     = run;
    game_over   = (state == OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bird_row     <= ROW_W'(START_ROW);
      score        <= '0;
      step_cnt     <= '0;
      flap_pending <= 1'b0;
      floor_hit    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bird_row     <= ROW_W'(START_ROW);
          score        <= '0;
          step_cnt     <= '0;
          flap_pending <= 1'b0;
          floor_hit    <= 1'b0;
        end
        PLAY: if (wrap) begin
          if (flap_pending)
            bird_row <= (int'(bird_row) >= FLAP_ROWS) ? bird_row - ROW_W'(FLAP_ROWS) : '0;
          else if (bird_row != ROW_LAST)
            bird_row <= bird_row + ROW_W'(1);
          floor_hit    <= !flap_pending && (bird_row == ROW_LAST);
          // a flap on the step edge belongs to the next step
          flap_pending <= flap;
        end else if (flap) begin
          flap_pending <= 1'b1;
        end
        CHECK: begin
          if (flap) flap_pending <= 1'b1;
          if (!crash) begin
            if (step_cnt == SW'(PIPE_PERIOD - 1)) begin
              step_cnt <= '0;
              if (score != SCORE_MAX) score <= score + SCORE_W'(1);
            end else begin
              step_cnt <= step_cnt + SW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed vector table plus randomized play checked against a cycle-level game model.
module tb_game_sequencer;

  localparam int TD = 4, FR = 2, PP = 4, SR = 3;

  logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, flap = 1'b0, dead = 1'b0;
  logic       scroll_en, clear_field, playing, game_over;
  logic [2:0] bird_row;
  logic [7:0] score;

  int vectors = 0, miscompares = 0;

  game_sequencer #(.TICK_DIV(TD), .FLAP_ROWS(FR), .PIPE_PERIOD(PP), .START_ROW(SR)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flap(flap), .dead(dead),
    .scroll_en(scroll_en), .clear_field(clear_field), .bird_row(bird_row),
    .score(score), .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st, fl, dd;
    bit sc, cl;
    int row, scr;
    bit pl, ov;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit st, fl, dd, sc, cl, input int row, scr, input bit pl, ov);
    vec_t v;
    v.st = st; v.fl = fl; v.dd = dd; v.sc = sc; v.cl = cl;
    v.row = row; v.scr = scr; v.pl = pl; v.ov = ov;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Game model: mode 0 idle, 1 in game, 2 over; t counts cycles since the start edge.
  int m_mode, m_t, m_row, m_score, m_steps;
  bit m_pend, m_floor;

  task automatic m_reset();
    m_mode = 0; m_t = 0; m_row = SR; m_score = 0; m_steps = 0; m_pend = 0; m_floor = 0;
  endtask

  task automatic m_step(input bit s, f, d);
    case (m_mode)
      0: if (s) begin
        m_mode = 1; m_t = 0; m_row = SR; m_score = 0; m_steps = 0; m_pend = 0; m_floor = 0;
      end
      1: begin
        if (m_t % TD == TD - 1) begin
          m_floor = 0;
          if (m_pend)          m_row = (m_row - FR < 0) ? 0 : m_row - FR;
          else if (m_row == 7) m_floor = 1;
          else                 m_row = m_row + 1;
          m_pend = f;
        end else begin
          if (m_t > 0 && m_t % TD == 0) begin
            if (d || m_floor) m_mode = 2;
            else begin
              m_steps++;
              if (m_steps == PP) begin
                m_steps = 0;
                if (m_score < 255) m_score++;
              end
            end
          end
          if (f) m_pend = 1;
        end
        m_t++;
      end
      default: if (s) m_mode = 0;
    endcase
  endtask

  task automatic cyc(input bit s, f, d);
    start = s; flap = f; dead = d;
    #1;
    vectors++;
    chk("scroll_en", int'(scroll_en), int'(m_mode == 1 && m_t % TD == TD - 1));
    chk("clear_field", int'(clear_field), int'(m_mode == 0 && s));
    chk("bird_row", int'(bird_row), m_row);
    chk("score", int'(score), m_score);
    chk("playing", int'(playing), int'(m_mode == 1));
    chk("game_over", int'(game_over), int'(m_mode == 2));
    @(posedge clk);
    m_step(s, f, d);
    @(negedge clk);
  endtask

  // 1 ns reset pulse between clock edges; outputs must drop immediately.
  task automatic pulse_reset();
    start = 0; flap = 0; dead = 0;
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    chk("async_rst.playing", int'(playing), 0);
    chk("async_rst.game_over", int'(game_over), 0);
    chk("async_rst.scroll_en", int'(scroll_en), 0);
    chk("async_rst.bird_row", int'(bird_row), SR);
    chk("async_rst.score", int'(score), 0);
    #1 reset_n = 1'b1;
    m_reset();
    @(negedge clk);
  endtask

  initial begin
    // start->clear, 4 falling steps, floor hit on 5th step
    add(1,0,0, 0,1, 3,0, 0,0);
    repeat (3) add(0,0,0, 0,0, 3,0, 1,0);
    add(0,0,0, 1,0, 3,0, 1,0);
    for (int r = 4; r <= 6; r++) begin
      repeat (3) add(0,0,0, 0,0, r,0, 1,0);
      add(0,0,0, 1,0, r,0, 1,0);
    end
    add(0,0,0, 0,0, 7,0, 1,0);
    repeat (2) add(0,0,0, 0,0, 7,1, 1,0);
    add(0,0,0, 1,0, 7,1, 1,0);
    add(0,0,0, 0,0, 7,1, 1,0);
    add(0,0,0, 0,0, 7,1, 0,1);
    add(1,0,0, 0,0, 7,1, 0,1);
    add(0,0,0, 0,0, 7,1, 0,0);
    add(1,0,0, 0,1, 7,1, 0,0);
    // flap clamp at row 0, flap on step edge carried to next step, dead in 3rd CHECK
    add(0,1,0, 0,0, 3,0, 1,0);
    repeat (2) add(0,0,0, 0,0, 3,0, 1,0);
    add(0,0,0, 1,0, 3,0, 1,0);
    add(0,1,0, 0,0, 1,0, 1,0);
    repeat (2) add(0,0,0, 0,0, 1,0, 1,0);
    add(0,1,0, 1,0, 1,0, 1,0);
    repeat (3) add(0,0,0, 0,0, 0,0, 1,0);
    add(0,0,0, 1,0, 0,0, 1,0);
    add(0,0,1, 0,0, 0,0, 1,0);
    add(0,0,0, 0,0, 0,0, 0,1);
    add(1,0,0, 0,0, 0,0, 0,1);
    add(1,0,0, 0,1, 0,0, 0,0);
    add(0,0,0, 0,0, 3,0, 1,0);

    @(negedge clk);
    #1;
    vectors++;
    chk("reset.bird_row", int'(bird_row), SR);
    chk("reset.score", int'(score), 0);
    chk("reset.playing", int'(playing), 0);
    chk("reset.game_over", int'(game_over), 0);
    chk("reset.scroll_en", int'(scroll_en), 0);
    chk("reset.clear_field", int'(clear_field), 0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      start = tbl[i].st; flap = tbl[i].fl; dead = tbl[i].dd;
      #1;
      vectors++;
      chk($sformatf("v%0d.scroll_en", i), int'(scroll_en), int'(tbl[i].sc));
      chk($sformatf("v%0d.clear_field", i), int'(clear_field), int'(tbl[i].cl));
      chk($sformatf("v%0d.bird_row", i), int'(bird_row), tbl[i].row);
      chk($sformatf("v%0d.score", i), int'(score), tbl[i].scr);
      chk($sformatf("v%0d.playing", i), int'(playing), int'(tbl[i].pl));
      chk($sformatf("v%0d.game_over", i), int'(game_over), int'(tbl[i].ov));
      @(posedge clk);
      @(negedge clk);
    end

    pulse_reset();

    // Long clean game: flap every third step keeps the bird in rows 3..5
    cyc(1, 0, 0);
    for (int k = 0; k < 1024 * TD + 2; k++) begin
      bit f;
      f = (m_mode == 1) && (m_t % TD == 1) && ((m_t / TD) % 3 == 2);
      cyc(0, f, 0);
      if (k == 8 * TD)    chk("score_after_8_steps", int'(score), 2);
      if (k == 1020 * TD) chk("score_reaches_255", int'(score), 255);
    end
    chk("score_saturated", int'(score), 255);
    chk("still_playing", int'(playing), 1);

    pulse_reset();

    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller for the 8x8 red/green LED playfield.
- Red is the bird, fixed in column 6. Green is the scrolling barriers.
- Divides the system clock into game steps and commands the barrier scroller. Moves the bird under gravity and flap input.
- Samples the bird/barrier collision flag once per step and keeps score. Holds game-over until restart.

Parameters:
- TICK_DIV, 25000000: clk cycles per game step; legal minimum 4.
- FLAP_ROWS, 2: rows the bird rises on a flap step.
- PIPE_PERIOD, 4: game steps per scored barrier.
- START_ROW, 3: bird row loaded at game start (row 0 = top, row 7 = bottom).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse, already debounced
- flap  input  1  one-cycle pulse, already debounced
- dead  input  1  collision flag from the playfield checker, combinational on the current arrays
- scroll_en  output  1  one-cycle pulse: barrier scroller shifts one column
- clear_field  output  1  one-cycle pulse: scroller clears green array
- bird_row  output  3  bird row index; red array column 6 decodes from it
- score  output  8  points, saturating
- playing  output  1  high in PLAY and CHECK
- game_over  output  1  high in OVER

Behaviour:
- Reset (async assert, sync release to first clk edge): state IDLE, bird_row=START_ROW, score=0, step counter=0, tick counter=0, flap_pending=0, all pulses 0.
- States: IDLE, PLAY, CHECK, OVER.
- IDLE:
  - start -> PLAY.
  - Same edge loads bird_row=START_ROW, score=0, tick counter=0, step counter=0, flap_pending=0.
  - clear_field high for exactly that one cycle.
- PLAY:
  - Tick counter increments every cycle.
  - At TICK_DIV-1 the counter wraps to 0 and scroll_en pulses for one cycle. The bird updates on the same edge, then -> CHECK.
  - Bird update, flap_pending=1: bird_row = max(bird_row - FLAP_ROWS, 0).
  - Bird update, flap_pending=0: bird_row = bird_row + 1. If bird_row was 7, set internal floor_hit and keep bird_row at 7.
  - flap_pending is cleared on the step edge.
  - A flap pulse on the same cycle as the step edge is latched for the next step, not the current one.
- CHECK (exactly one cycle; barriers and bird have settled):
  - dead=1 or floor_hit=1 -> OVER; score unchanged.
  - Otherwise: step counter increments. When it reaches PIPE_PERIOD it wraps to 0 and score increments, saturating at 255. Then -> PLAY.
  - The tick counter keeps running through CHECK. Step spacing stays exactly TICK_DIV cycles.
- flap pulses are accepted in PLAY and CHECK and ignored in IDLE and OVER.
- OVER: bird_row and score are frozen; scroll_en stays 0; start -> IDLE.
- start is ignored in PLAY and CHECK (no mid-game restart).
- Latencies:
  - start in IDLE to first scroll_en: TICK_DIV cycles.
  - Collision at a step to game_over: game_over is high 2 cycles after the scroll_en pulse.
- reset_n low mid-game returns to IDLE immediately. Outputs take their reset values asynchronously.

Optional Feature:
- Macro SEQ_SPEEDUP_EN.
- Defined: effective step period = TICK_DIV - (score/8)*(TICK_DIV/8), floored at TICK_DIV/4. The new period is recomputed at each CHECK and takes effect from the next tick-counter wrap.
- Undefined: period fixed at TICK_DIV; no divider or comparator logic generated.

Decomposition:
- Shared package game_pkg holds:
  - state enum game_state_t {IDLE, PLAY, CHECK, OVER}
  - BIRD_COL=6
  - ROWS=8
  - SCORE_W=8
- One sub-module, step_timer: the tick counter with wrap pulse. Its period is an input port so SEQ_SPEEDUP_EN only changes the driver of that port.

Test Plan:
- Reset, then start with TICK_DIV=4, START_ROW=3, no flap -> clear_field one cycle; scroll_en every 4 cycles; bird_row 4,5,6,7.
- Next step after bird_row=7, dead=0 -> game_over rises 2 cycles after that scroll_en; bird_row stays 7; scroll_en stops.
- Flap before first step, bird_row=1, FLAP_ROWS=2 -> bird_row=0 (clamped). Flap on the exact step edge applies at the following step.
- dead forced 1 in the CHECK cycle after the 3rd step -> OVER with score=0. Start -> IDLE; second start -> PLAY with score=0 and bird_row=3.
- 8 clean steps with PIPE_PERIOD=4 and flaps keeping the bird in range -> score=2. Preloading score to 255 and completing 4 more clean steps leaves score=255.
- reset_n pulsed low mid-PLAY for 1 ns between clk edges -> immediate IDLE, score=0, bird_row=3, no scroll_en. Only with SEQ_SPEEDUP_EN: score=8, TICK_DIV=64 -> step spacing 56.
